// File: rtl/prism_sp_cookie_rr_scheduler_if.sv
// Bundle of the scheduler's control, source-FIFO and destination-FIFO signals.
// The scheduler takes the master side; whatever models the FIFOs takes the slave side.
interface prism_sp_cookie_rr_scheduler_if #(
    parameter int N_SRC       = 4,
    parameter int DATA_WIDTH  = 64,
    parameter int QUOTA_WIDTH = 4,
    parameter int SRC_WIDTH   = $clog2(N_SRC)
);
    logic                         enable;
    logic [N_SRC*QUOTA_WIDTH-1:0] quota_cfg;
    logic [N_SRC-1:0]             in_empty;
    logic [N_SRC-1:0]             in_rd_en;
    logic [N_SRC*DATA_WIDTH-1:0]  in_data;
    logic                         out_full;
    logic                         out_wr_en;
    logic [DATA_WIDTH-1:0]        out_data;
    logic [SRC_WIDTH-1:0]         out_src;
    logic                         busy;
    logic [31:0]                  pushed_count;

    modport master (
        input  enable, quota_cfg, in_empty, in_data, out_full,
        output in_rd_en, out_wr_en, out_data, out_src, busy, pushed_count
    );

    modport slave (
        output enable, quota_cfg, in_empty, in_data, out_full,
        input  in_rd_en, out_wr_en, out_data, out_src, busy, pushed_count
    );
endinterface

// File: rtl/prism_sp_cookie_rr_scheduler.sv
// Weighted round-robin merge of N non-FWFT cookie FIFOs into one destination FIFO.
// Each grant pops, registers and pushes cookies (tagged with source) up to its burst quota.
module prism_sp_cookie_rr_scheduler #(
    parameter int N_SRC       = 4,
    parameter int DATA_WIDTH  = 64,
    parameter int QUOTA_WIDTH = 4,
    parameter int SRC_WIDTH   = $clog2(N_SRC)
) (
    input logic clock,
    input logic reset,
    prism_sp_cookie_rr_scheduler_if.master bus
);

    typedef enum logic [1:0] {IDLE, POP, LOAD, PUSH} state_e;

    state_e                 state_q, state_d;
    logic [SRC_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [SRC_WIDTH-1:0]   grant_q, grant_d;
    logic [QUOTA_WIDTH-1:0] quota_left_q, quota_left_d;
    logic [DATA_WIDTH-1:0]  hold_data_q, hold_data_d;
    logic [SRC_WIDTH-1:0]   hold_src_q, hold_src_d;
    logic [31:0]            count_q, count_d;

    logic                   found;
    logic [SRC_WIDTH-1:0]   cand;
    logic [SRC_WIDTH-1:0]   pick;
    logic [QUOTA_WIDTH-1:0] pick_quota;
    logic [SRC_WIDTH-1:0]   next_ptr;
    logic [N_SRC-1:0]       rd_en;
    logic                   wr_en;

    // First non-empty source at or after rr_ptr; a zero quota is promoted to one.
    always_comb begin
        found      = 1'b0;
        cand       = '0;
        pick       = '0;
        pick_quota = '0;
        for (int k = 0; k < N_SRC; k++) begin
            cand = SRC_WIDTH'((int'(rr_ptr_q) + k) % N_SRC);
            if (!found && !bus.in_empty[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        pick_quota = bus.quota_cfg[int'(pick)*QUOTA_WIDTH +: QUOTA_WIDTH];
        if (pick_quota == '0) begin
            pick_quota = QUOTA_WIDTH'(1);
        end
    end

    assign next_ptr = (grant_q == SRC_WIDTH'(N_SRC - 1)) ? '0 : grant_q + SRC_WIDTH'(1);

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_d      = grant_q;
        quota_left_d = quota_left_q;
        hold_data_d  = hold_data_q;
        hold_src_d   = hold_src_q;
        count_d      = count_q;
        rd_en        = '0;
        wr_en        = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.enable && found) begin
                    grant_d      = pick;
                    quota_left_d = pick_quota;
                    state_d      = POP;
                end
            end
            POP: begin
                rd_en[grant_q] = 1'b1;
                state_d        = LOAD;
            end
            LOAD: begin
                hold_data_d = bus.in_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
                hold_src_d  = grant_q;
                state_d     = PUSH;
            end
            PUSH: begin
                // Once popped, a cookie is always pushed; enable only gates the next pop.
                if (!bus.out_full) begin
                    wr_en        = 1'b1;
                    count_d      = count_q + 32'd1;
                    quota_left_d = quota_left_q - QUOTA_WIDTH'(1);
                    if (quota_left_d != '0 && bus.enable && !bus.in_empty[grant_q]) begin
                        state_d = POP;
                    end else begin
                        rr_ptr_d = next_ptr;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            quota_left_q <= '0;
            hold_data_q  <= '0;
            hold_src_q   <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            quota_left_q <= quota_left_d;
            hold_data_q  <= hold_data_d;
            hold_src_q   <= hold_src_d;
            count_q      <= count_d;
        end
    end

    assign bus.in_rd_en     = rd_en;
    assign bus.out_wr_en    = wr_en;
    assign bus.out_data     = hold_data_q;
    assign bus.out_src      = hold_src_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.pushed_count = count_q;

    a_rd_not_empty: assert property (@(posedge clock) disable iff (reset)
        (bus.in_rd_en & bus.in_empty) == '0);
    a_rd_onehot: assert property (@(posedge clock) disable iff (reset)
        $onehot0(bus.in_rd_en));
    a_wr_not_full: assert property (@(posedge clock) disable iff (reset)
        !(bus.out_wr_en && bus.out_full));

endmodule

// File: tb/tb_prism_sp_cookie_rr_scheduler.sv
// Directed bench for the cookie round-robin scheduler: FIFO models on the slave side,
// a push/pop logger, and hand-computed expected sequences for each scenario.
module tb_prism_sp_cookie_rr_scheduler;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int QW = 4;
    localparam int SW = 2;

    logic clock;
    logic reset;

    prism_sp_cookie_rr_scheduler_if #(.N_SRC(N), .DATA_WIDTH(DW), .QUOTA_WIDTH(QW), .SRC_WIDTH(SW)) bus();

    prism_sp_cookie_rr_scheduler #(.N_SRC(N), .DATA_WIDTH(DW), .QUOTA_WIDTH(QW), .SRC_WIDTH(SW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] fifoMem [N][16];
    int            wrPtr [N];
    int            rdPtr [N];

    int            cycleCnt = 0;
    logic [SW-1:0] pushSrc [$];
    logic [DW-1:0] pushData [$];
    int            pushCyc [$];
    int            rdSrc [$];
    int            rdCyc [$];
    int            rdEmptyViol = 0;
    int            rdMultiViol = 0;
    int            wrFullViol = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cycleCnt <= cycleCnt + 1;

    for (genvar g = 0; g < N; g++) begin : gEmpty
        assign bus.in_empty[g] = (rdPtr[g] == wrPtr[g]);
    end

    // Non-FWFT source FIFOs: data for a pop shows up the cycle after in_rd_en.
    always @(posedge clock) begin
        for (int i = 0; i < N; i++) begin
            if (bus.in_rd_en[i] === 1'b1) begin
                bus.in_data[i*DW +: DW] <= fifoMem[i][rdPtr[i] % 16];
                rdPtr[i] <= rdPtr[i] + 1;
            end
        end
    end

    // Log every push and pop a little after the falling edge, once inputs have settled.
    always @(negedge clock) begin
        #1;
        if (reset === 1'b0) begin
            if (bus.out_wr_en === 1'b1) begin
                pushSrc.push_back(bus.out_src);
                pushData.push_back(bus.out_data);
                pushCyc.push_back(cycleCnt);
                if (bus.out_full !== 1'b0) wrFullViol++;
            end
            if (bus.in_rd_en != '0) begin
                for (int i = 0; i < N; i++) begin
                    if (bus.in_rd_en[i]) rdSrc.push_back(i);
                end
                rdCyc.push_back(cycleCnt);
                if ($countones(bus.in_rd_en) > 1) rdMultiViol++;
                if ((bus.in_rd_en & bus.in_empty) != '0) rdEmptyViol++;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int src, input logic [DW-1:0] value);
        fifoMem[src][wrPtr[src] % 16] = value;
        wrPtr[src] = wrPtr[src] + 1;
    endtask

    task automatic doReset();
        bus.enable    = 1'b0;
        bus.out_full  = 1'b0;
        bus.quota_cfg = '0;
        reset = 1'b1;
        for (int i = 0; i < N; i++) wrPtr[i] = rdPtr[i];
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic waitPushes(input int base, input int n, input int budget);
        int cyc = 0;
        while ((pushSrc.size() - base) < n && cyc < budget) begin
            @(negedge clock);
            cyc++;
        end
        if ((pushSrc.size() - base) < n) checkOutput("waitTimeout", 64'(pushSrc.size() - base), 64'(n));
    endtask

    initial begin
        int pb;
        int rb;
        int cyc;
        int dropCyc;
        logic [SW-1:0] expSrc3 [12];
        logic [DW-1:0] expData3 [12];

        expSrc3  = '{0, 1, 1, 2, 2, 2, 3, 0, 1, 3, 0, 3};
        expData3 = '{64'h00, 64'h10, 64'h11, 64'h20, 64'h21, 64'h22,
                     64'h30, 64'h01, 64'h12, 64'h31, 64'h02, 64'h32};

        bus.enable    = 1'b0;
        bus.out_full  = 1'b0;
        bus.quota_cfg = '0;
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Reset values while reset is held
        checkOutput("rstRdEn", 64'(bus.in_rd_en), 64'h0);
        checkOutput("rstWrEn", 64'(bus.out_wr_en), 64'h0);
        checkOutput("rstData", bus.out_data, 64'h0);
        checkOutput("rstSrc", 64'(bus.out_src), 64'h0);
        checkOutput("rstBusy", 64'(bus.busy), 64'h0);
        checkOutput("rstCount", 64'(bus.pushed_count), 64'h0);

        // Single requester, source 2, quota 2
        doReset();
        bus.quota_cfg = {4{4'd2}};
        for (int k = 0; k < 5; k++) applyStimulus(2, 64'hA0 + 64'(k));
        pb = pushSrc.size();
        rb = rdSrc.size();
        bus.enable = 1'b1;
        waitPushes(pb, 5, 100);
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("solo.data%0d", k), pushData[pb+k], 64'hA0 + 64'(k));
            checkOutput($sformatf("solo.src%0d", k), 64'(pushSrc[pb+k]), 64'd2);
        end
        checkOutput("solo.latency", 64'(pushCyc[pb] - rdCyc[rb]), 64'd2);
        repeat (3) @(negedge clock);
        checkOutput("solo.count", 64'(bus.pushed_count), 64'd5);
        checkOutput("solo.pops", 64'(rdSrc.size() - rb), 64'd5);
        checkOutput("solo.busyEnd", 64'(bus.busy), 64'd0);

        // Four requesters, quotas {1,2,3,0}
        doReset();
        bus.quota_cfg = {4'd0, 4'd3, 4'd2, 4'd1};
        for (int s = 0; s < N; s++)
            for (int k = 0; k < 3; k++) applyStimulus(s, 64'(s * 16 + k));
        pb = pushSrc.size();
        bus.enable = 1'b1;
        waitPushes(pb, 12, 200);
        for (int k = 0; k < 12; k++) begin
            checkOutput($sformatf("wrr.src%0d", k), 64'(pushSrc[pb+k]), 64'(expSrc3[k]));
            checkOutput($sformatf("wrr.data%0d", k), pushData[pb+k], expData3[k]);
        end
        repeat (3) @(negedge clock);
        checkOutput("wrr.count", 64'(bus.pushed_count), 64'd12);

        // Destination full across PUSH entry and for ten cycles after
        doReset();
        bus.quota_cfg = {4{4'd1}};
        applyStimulus(1, 64'h55);
        bus.out_full = 1'b1;
        pb = pushSrc.size();
        rb = rdSrc.size();
        bus.enable = 1'b1;
        repeat (13) @(negedge clock);
        checkOutput("full.noWrites", 64'(pushSrc.size() - pb), 64'd0);
        checkOutput("full.wrEn", 64'(bus.out_wr_en), 64'd0);
        checkOutput("full.busy", 64'(bus.busy), 64'd1);
        checkOutput("full.holdData", bus.out_data, 64'h55);
        dropCyc = cycleCnt;
        bus.out_full = 1'b0;
        repeat (6) @(negedge clock);
        checkOutput("full.oneWrite", 64'(pushSrc.size() - pb), 64'd1);
        checkOutput("full.data", pushData[pb], 64'h55);
        checkOutput("full.src", 64'(pushSrc[pb]), 64'd1);
        checkOutput("full.firstFreeCycle", 64'(pushCyc[pb]), 64'(dropCyc));
        checkOutput("full.pops", 64'(rdSrc.size() - rb), 64'd1);
        checkOutput("full.count", 64'(bus.pushed_count), 64'd1);

        // Enable drops during LOAD of source 1
        doReset();
        bus.quota_cfg = {4{4'd4}};
        applyStimulus(1, 64'hB0);
        applyStimulus(1, 64'hB1);
        applyStimulus(1, 64'hB2);
        pb = pushSrc.size();
        rb = rdSrc.size();
        bus.enable = 1'b1;
        cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
        end while (bus.in_rd_en == '0 && cyc < 10);
        checkOutput("drop.pop", 64'(bus.in_rd_en), 64'h2);
        @(negedge clock);
        bus.enable = 1'b0;
        @(negedge clock);
        checkOutput("drop.wrEn", 64'(bus.out_wr_en), 64'd1);
        checkOutput("drop.data", bus.out_data, 64'hB0);
        @(negedge clock);
        checkOutput("drop.busyOff", 64'(bus.busy), 64'd0);
        repeat (5) @(negedge clock);
        checkOutput("drop.pops", 64'(rdSrc.size() - rb), 64'd1);
        checkOutput("drop.pushes", 64'(pushSrc.size() - pb), 64'd1);
        checkOutput("drop.count", 64'(bus.pushed_count), 64'd1);

        // Source 0 runs dry under quota 3; grant moves to source 3
        doReset();
        bus.quota_cfg = {4'd1, 4'd1, 4'd1, 4'd3};
        applyStimulus(0, 64'hC0);
        applyStimulus(3, 64'hD0);
        pb = pushSrc.size();
        rb = rdSrc.size();
        bus.enable = 1'b1;
        waitPushes(pb, 2, 50);
        repeat (3) @(negedge clock);
        checkOutput("dry.src0", 64'(pushSrc[pb]), 64'd0);
        checkOutput("dry.data0", pushData[pb], 64'hC0);
        checkOutput("dry.src1", 64'(pushSrc[pb+1]), 64'd3);
        checkOutput("dry.data1", pushData[pb+1], 64'hD0);
        checkOutput("dry.pops", 64'(rdSrc.size() - rb), 64'd2);
        checkOutput("dry.popSrc1", 64'(rdSrc[rb+1]), 64'd3);
        checkOutput("dry.count", 64'(bus.pushed_count), 64'd2);

        // Asynchronous reset while stalled in PUSH
        bus.quota_cfg = {4{4'd1}};
        applyStimulus(2, 64'h77);
        bus.out_full = 1'b1;
        repeat (6) @(negedge clock);
        checkOutput("arst.busyBefore", 64'(bus.busy), 64'd1);
        checkOutput("arst.dataBefore", bus.out_data, 64'h77);
        reset = 1'b1;
        #1;
        checkOutput("arst.rdEn", 64'(bus.in_rd_en), 64'h0);
        checkOutput("arst.wrEn", 64'(bus.out_wr_en), 64'h0);
        checkOutput("arst.data", bus.out_data, 64'h0);
        checkOutput("arst.src", 64'(bus.out_src), 64'h0);
        checkOutput("arst.busy", 64'(bus.busy), 64'h0);
        checkOutput("arst.count", 64'(bus.pushed_count), 64'h0);
        bus.out_full = 1'b0;
        bus.enable   = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("arst.busyAfter", 64'(bus.busy), 64'd0);
        checkOutput("arst.countAfter", 64'(bus.pushed_count), 64'd0);

        checkOutput("inv.rdEmpty", 64'(rdEmptyViol), 64'd0);
        checkOutput("inv.rdOneHot", 64'(rdMultiViol), 64'd0);
        checkOutput("inv.wrFull", 64'(wrFullViol), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prism_sp_cookie_rr_scheduler.md
Name: prism_sp_cookie_rr_scheduler

Overview:
- Weighted round-robin scheduler that merges N cookie FIFO streams into one downstream cookie FIFO.
- Example producers: ring-acquire outputs of several RX queues feeding one shared DMA-write stage.
- Pops a cookie from the granted source FIFO, registers it, and pushes it tagged with its source index.
- Each source keeps the grant for up to a programmable burst quota, then the grant rotates.

Parameters:
- N_SRC, 4, number of source cookie FIFOs (2..8).
- DATA_WIDTH, 64, cookie width in bits.
- QUOTA_WIDTH, 4, width of each per-source quota field.
- SRC_WIDTH, $clog2(N_SRC), width of the source tag.

Ports:
- clock  in  1  single clock domain.
- reset  in  1  asynchronous reset, active-high.
- enable  in  1  scheduler run enable.
- quota_cfg  in  N_SRC*QUOTA_WIDTH  per-source burst quota; field i = bits [i*QUOTA_WIDTH +: QUOTA_WIDTH].
- in_empty  in  N_SRC  source FIFO empty flags.
- in_rd_en  out  N_SRC  source FIFO pop strobes, one-hot or zero.
- in_data  in  N_SRC*DATA_WIDTH  source FIFO read data, valid the cycle after in_rd_en.
- out_full  in  1  destination FIFO full.
- out_wr_en  out  1  destination FIFO write strobe.
- out_data  out  DATA_WIDTH  cookie to destination.
- out_src  out  SRC_WIDTH  source index of out_data.
- busy  out  1  high whenever state != IDLE.
- pushed_count  out  32  total cookies pushed; wraps modulo 2^32.

Behaviour:
- Reset (asynchronous, active-high), values held while reset is high:
  - in_rd_en=0, out_wr_en=0, out_data=0, out_src=0, busy=0, pushed_count=0.
  - rr_ptr=0, grant=0, quota_left=0, hold register=0, state=IDLE.
- FIFO read semantics are non-FWFT: data appears on in_data one cycle after in_rd_en.
- State machine:
  - IDLE:
    - If enable=1 and any in_empty[i]=0, pick the first non-empty source scanning rr_ptr, rr_ptr+1, ... modulo N_SRC.
    - Latch grant=g and quota_left = max(quota_cfg[g],1); quota 0 is treated as 1.
    - Go to POP. Otherwise stay in IDLE.
  - POP: in_rd_en[grant]=1 for exactly this cycle (in_empty[grant]=0 is guaranteed by entry condition). Go to LOAD.
  - LOAD: capture in_data[grant] and grant into the hold register. Go to PUSH.
  - PUSH:
    - out_data and out_src are driven from the hold register.
    - out_wr_en = !out_full. Stay in PUSH while out_full=1, with no timeout.
    - On the write cycle: increment pushed_count and decrement quota_left.
    - Next state: if quota_left after decrement > 0, enable=1 and in_empty[grant]=0, go to POP with the same grant.
    - Otherwise set rr_ptr = (grant+1) mod N_SRC and go to IDLE.
- Throughput: max one cookie per 3 cycles within a burst; 4 cycles when the grant changes (IDLE arbitration cycle).
- Latency: in_rd_en to out_wr_en is 2 cycles when out_full=0.
- out_data/out_src hold their last value when out_wr_en=0, which is legal to observe.
- Boundary conditions:
  - enable deasserted mid-item: a popped cookie is never dropped. POP/LOAD/PUSH complete, then go to IDLE; no further pops.
  - quota_cfg changes mid-burst: no effect until the next grant (sampled in IDLE only).
  - Granted source goes empty mid-burst: the burst ends early and rr_ptr advances.
  - Simultaneous requests: strict rotation from rr_ptr. A requester is never starved while others are served within their quotas.
  - Single requester: re-granted immediately on the next IDLE cycle.
  - out_full asserted in the same cycle PUSH is entered: no write that cycle; the write happens on the first cycle out_full=0.
- Invariants checked by assertions:
  - in_rd_en never asserted for a source with in_empty=1.
  - in_rd_en at most one-hot.
  - out_wr_en never asserted while out_full=1.

Test Plan:
- Reset mid-PUSH with out_full=1 -> all outputs 0 immediately (asynchronously); after release, busy=0 and pushed_count=0.
- Source 2 only, 5 cookies 0xA0..0xA4, quota=2, out_full=0 -> out_data sequence A0..A4 all with out_src=2; pushed_count=5; in_rd_en to out_wr_en = 2 cycles.
- All 4 sources hold 3 cookies, quotas {1,2,3,0} -> push order by source 0,1,1,2,2,2,3,0,1,3,0,3 (each quota then rotate; quota 0 acts as 1); pushed_count=12.
- out_full held high 10 cycles during PUSH of 0x55 -> out_wr_en stays 0; exactly one write of 0x55 on the first cycle out_full=0; no extra pops.
- enable drops the cycle after POP of source 1, quota 4 -> that cookie is still pushed; no further in_rd_en; busy=0 two cycles later.
- Source 0 empties after 1 cookie with quota 3, source 3 non-empty -> grant moves to source 3 with no dead POP on source 0.
